// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: a - b - b_in computed one nibble per clock, LSB first,
// around a combinational 4-bit ripple-borrow slice. start/busy/done handshake.

module ripple_borrow_adder_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       b_in,
  output logic [3:0] diff,
  output logic       borrow
);

  always_comb begin
    logic bw;
    bw   = b_in;
    diff = '0;
    for (int i = 0; i < 4; i++) begin
      diff[i] = a[i] ^ b[i] ^ bw;
      bw      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
    end
    borrow = bw;
  end

endmodule

module nibble_serial_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CntW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             borrow_q, borrow_d, borrow_out_q, borrow_out_d, zero_q, zero_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [CntW+1:0]  nib_idx;
  logic [3:0]       slice_a, slice_b, slice_diff;
  logic             slice_borrow;
  logic             last_nibble;

  assign nib_idx     = {cnt_q, 2'b00};
  assign slice_a     = a_q[nib_idx +: 4];
  assign slice_b     = b_q[nib_idx +: 4];
  assign last_nibble = (cnt_q == CntW'(NIBBLES - 1));

  ripple_borrow_adder_4_bit u_slice (
    .a      (slice_a),
    .b      (slice_b),
    .b_in   (borrow_q),
    .diff   (slice_diff),
    .borrow (slice_borrow)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    cnt_d        = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = b_in;
          cnt_d    = '0;
          diff_d   = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        diff_d[nib_idx +: 4] = slice_diff;
        borrow_d             = slice_borrow;
        if (last_nibble) begin
          state_d      = StDone;
          borrow_out_d = slice_borrow;
          // diff_d already holds the final nibble here
          zero_d       = (diff_d == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
      cnt_q        <= cnt_d;
    end
  end

  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor: 16-bit and 8-bit instances, directed vectors.

module tb_nibble_serial_subtractor;

  typedef struct {
    logic [15:0] diff;
    logic        bor;
    logic        zr;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        start16 = 1'b0, b_in16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, borrow16, zero16;
  logic [15:0] diff16;

  logic        start8 = 1'b0, b_in8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, borrow8, zero8;
  logic [7:0]  diff8;

  exp_t        q16[$];
  exp_t        q8[$];
  int          bc16 = 0, bc8 = 0;

  nibble_serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .b_in(b_in16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(borrow16), .zero(zero16)
  );

  nibble_serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .b_in(b_in8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8), .zero(zero8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc16 = 0;
    end else begin
      if (busy16) bc16++;
      if (done16) begin
        if (q16.size() == 0) begin
          chk("w16 unexpected done", 1, 0);
        end else begin
          exp_t e;
          e = q16.pop_front();
          chk("w16 diff", {16'h0, diff16}, {16'h0, e.diff});
          chk("w16 borrow_out", {31'h0, borrow16}, {31'h0, e.bor});
          chk("w16 zero", {31'h0, zero16}, {31'h0, e.zr});
          chk("w16 done cycle", cyc, e.cyc);
          chk("w16 busy cycles", bc16, 4);
        end
        bc16 = 0;
      end
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc8 = 0;
    end else begin
      if (busy8) bc8++;
      if (done8) begin
        if (q8.size() == 0) begin
          chk("w8 unexpected done", 1, 0);
        end else begin
          exp_t e;
          e = q8.pop_front();
          chk("w8 diff", {24'h0, diff8}, {24'h0, e.diff[7:0]});
          chk("w8 borrow_out", {31'h0, borrow8}, {31'h0, e.bor});
          chk("w8 zero", {31'h0, zero8}, {31'h0, e.zr});
          chk("w8 done cycle", cyc, e.cyc);
          chk("w8 busy cycles", bc8, 2);
        end
        bc8 = 0;
      end
    end
  end

  task automatic wait_idle16();
    int k = 0;
    @(negedge clk);
    while ((busy16 || done16) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("w16 idle timeout", 1, 0);
  endtask

  task automatic wait_idle8();
    int k = 0;
    @(negedge clk);
    while ((busy8 || done8) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("w8 idle timeout", 1, 0);
  endtask

  task automatic issue16(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                         input logic [15:0] ed, input logic eb, input logic ez);
    wait_idle16();
    start16 = 1'b1; a16 = av; b16 = bv; b_in16 = bi;
    q16.push_back('{ed, eb, ez, cyc + 1 + 4});
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        input logic [7:0] ed, input logic eb, input logic ez);
    wait_idle8();
    start8 = 1'b1; a8 = av; b8 = bv; b_in8 = bi;
    q8.push_back('{{8'h0, ed}, eb, ez, cyc + 1 + 2});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  initial begin
    int k;
    int d;
    #12;
    chk("reset busy", {31'h0, busy16}, 0);
    chk("reset done", {31'h0, done16}, 0);
    chk("reset diff", {16'h0, diff16}, 0);
    rst_n = 1'b1;

    issue16(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    a16 = 16'hFFFF; b16 = 16'hFFFF; // operand changes after accept must not matter
    issue16(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    issue16(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    issue16(16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1);
    wait_idle16();
    for (int i = 0; i < 10; i++) begin
      chk("hold diff", {16'h0, diff16}, 0);
      chk("hold borrow", {31'h0, borrow16}, 0);
      chk("hold zero", {31'h0, zero16}, 1);
      @(negedge clk);
    end

    // Re-pulse during RUN is ignored; start held through DONE accepts the next op.
    issue16(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0);
    start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000; b_in16 = 1'b0;
    @(negedge clk);
    k = 0;
    while (!done16 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("repulse done timeout", 1, 0);
    d = cyc;
    a16 = 16'h5555; b16 = 16'h1111; b_in16 = 1'b1;
    q16.push_back('{16'h4443, 1'b0, 1'b0, d + 2 + 4});
    k = 0;
    while (!busy16 && k < 10) begin
      @(negedge clk);
      k++;
    end
    start16 = 1'b0;
    chk("second op accepted", {31'h0, busy16}, 1);

    // Asynchronous reset mid-RUN.
    wait_idle16();
    start16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; b_in16 = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", {31'h0, busy16}, 0);
    chk("async rst done", {31'h0, done16}, 0);
    chk("async rst diff", {16'h0, diff16}, 0);
    chk("async rst borrow", {31'h0, borrow16}, 0);
    chk("async rst zero", {31'h0, zero16}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue16(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);

    issue8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    issue8(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1);

    wait_idle16();
    wait_idle8();
    chk("w16 queue drained", q16.size(), 0);
    chk("w8 queue drained", q8.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
